// File: rtl/instruction_fetch_aligner_pkg.sv
// Shared widths, FSM encoding and opcode helpers for the fetch aligner and the
// compressed-instruction expander.
package instruction_fetch_aligner_pkg;

   localparam int HW_W      = 16;
   localparam int BUF_DEPTH = 4;

   localparam logic [1:0] OPC_UNCOMPRESSED = 2'b11;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BUSY  = 2'd1,
      DRAIN = 2'd2
   } fetch_state_e;

   function automatic logic is_compressed(input logic [HW_W-1:0] hw);
      return hw[1:0] != OPC_UNCOMPRESSED;
   endfunction

endpackage

// File: rtl/instruction_fetch_aligner_buffer.sv
// Four-entry halfword shift FIFO: pop 0/1/2 from the head, append 0/1/2 at the tail.
module halfword_buffer
   import instruction_fetch_aligner_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clear,
   input  logic [1:0]        push_cnt,
   input  logic [2*HW_W-1:0] push_data,
   input  logic [1:0]        pop_cnt,
   output logic [HW_W-1:0]   h0,
   output logic [HW_W-1:0]   h1,
   output logic [2:0]        count
);

   logic [HW_W-1:0] slots      [BUF_DEPTH];
   logic [HW_W-1:0] slots_next [BUF_DEPTH];
   logic [2:0]      base;
   logic [2:0]      count_next;
   logic [1:0]      src;

   // Survivors shift down by pop_cnt; new halfwords land right after them and
   // everything beyond the fill level is zeroed so an empty head reads as 0.
   always_comb begin
      base       = count - {1'b0, pop_cnt};
      count_next = base + {1'b0, push_cnt};
      src        = '0;
      for (int i = 0; i < BUF_DEPTH; i++) begin
         slots_next[i] = '0;
         src           = 2'(i) + pop_cnt;
         if (i < int'(base))
            slots_next[i] = slots[src];
         else if (i < int'(base) + int'(push_cnt))
            slots_next[i] = (i == int'(base)) ? push_data[HW_W-1:0]
                                               : push_data[2*HW_W-1:HW_W];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
         for (int i = 0; i < BUF_DEPTH; i++) slots[i] <= '0;
      end else if (clear) begin
         count <= '0;
         for (int i = 0; i < BUF_DEPTH; i++) slots[i] <= '0;
      end else begin
         count <= count_next;
         for (int i = 0; i < BUF_DEPTH; i++) slots[i] <= slots_next[i];
      end
   end

   assign h0 = slots[0];
   assign h1 = slots[1];

endmodule

// File: rtl/instruction_fetch_aligner.sv
// Fetch aligner: owns the fetch PC, keeps one word request in flight and
// presents whole 16/32-bit instructions to decode from a halfword buffer.
//
// state | meaning
// IDLE  | nothing outstanding; request when the buffer holds 2 or fewer halfwords
// BUSY  | one request outstanding; its response is appended to the buffer
// DRAIN | one stale request outstanding after a flush; its response is dropped
module instruction_fetch_aligner
   import instruction_fetch_aligner_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        flush,
   input  logic [31:0] flushPc,
   output logic        fetchReqValid,
   input  logic        fetchReqReady,
   output logic [31:0] fetchReqAddr,
   input  logic        fetchRespValid,
   input  logic [31:0] fetchRespData,
   output logic        instValid,
   input  logic        instReady,
   output logic [31:0] instData,
   output logic [31:0] instPc,
   output logic        instIsCompressed
);

   fetch_state_e    state;
   fetch_state_e    state_next;
   logic [31:0]     fetch_pc;
   logic [31:0]     head_pc;
   logic            skip_low;
   logic [HW_W-1:0] h0;
   logic [HW_W-1:0] h1;
   logic [2:0]      count;
   logic            head_compressed;
   logic            req_fire;
   logic            consume;
   logic            resp_take;
   logic [1:0]      pop_cnt;
   logic [1:0]      push_cnt;
   logic [31:0]     push_data;

   assign head_compressed  = is_compressed(h0);
   assign instValid        = ((count >= 3'd1) && head_compressed) || (count >= 3'd2);
   assign instData         = head_compressed ? {16'h0, h0} : {h1, h0};
   assign instPc           = head_pc;
   assign instIsCompressed = head_compressed;

   assign fetchReqValid = (state == IDLE) && (count <= 3'd2) && !flush;
   assign fetchReqAddr  = fetch_pc;

   assign req_fire  = fetchReqValid && fetchReqReady;
   assign consume   = instValid && instReady && !flush;
   assign resp_take = (state == BUSY) && fetchRespValid && !flush;

   assign pop_cnt   = consume ? (head_compressed ? 2'd1 : 2'd2) : 2'd0;
   assign push_cnt  = resp_take ? (skip_low ? 2'd1 : 2'd2) : 2'd0;
   // A redirect into the upper halfword keeps only bits [31:16] of the first word.
   assign push_data = skip_low ? {16'h0, fetchRespData[31:16]} : fetchRespData;

   halfword_buffer u_buffer (
      .clk       (clk),
      .rst_n     (rst_n),
      .clear     (flush),
      .push_cnt  (push_cnt),
      .push_data (push_data),
      .pop_cnt   (pop_cnt),
      .h0        (h0),
      .h1        (h1),
      .count     (count)
   );

   always_comb begin
      state_next = state;
      if (flush) begin
         unique case (state)
            IDLE:    state_next = IDLE;
            BUSY:    state_next = fetchRespValid ? IDLE : DRAIN;
            DRAIN:   state_next = fetchRespValid ? IDLE : DRAIN;
            default: state_next = IDLE;
         endcase
      end else begin
         unique case (state)
            IDLE:    if (req_fire) state_next = BUSY;
            BUSY:    if (fetchRespValid) state_next = IDLE;
            DRAIN:   if (fetchRespValid) state_next = IDLE;
            default: state_next = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         fetch_pc <= {RESET_PC[31:2], 2'b00};
         head_pc  <= {RESET_PC[31:1], 1'b0};
         skip_low <= RESET_PC[1];
      end else begin
         state <= state_next;
         if (flush) begin
            fetch_pc <= {flushPc[31:2], 2'b00};
            head_pc  <= {flushPc[31:1], 1'b0};
            skip_low <= flushPc[1];
         end else begin
            if (req_fire)
               fetch_pc <= fetch_pc + 32'd4;
            if (consume)
               head_pc <= head_pc + (head_compressed ? 32'd2 : 32'd4);
            if (resp_take && skip_low)
               skip_low <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_instruction_fetch_aligner.sv
// Directed bench for instruction_fetch_aligner with a word memory model of
// programmable latency driven from the same process as the stimulus.
module tb_instruction_fetch_aligner;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        flush;
   logic [31:0] flushPc;
   logic        fetchReqValid;
   logic        fetchReqReady;
   logic [31:0] fetchReqAddr;
   logic        fetchRespValid;
   logic [31:0] fetchRespData;
   logic        instValid;
   logic        instReady;
   logic [31:0] instData;
   logic [31:0] instPc;
   logic        instIsCompressed;

   int checks = 0;
   int errors = 0;

   logic [31:0] mem [256];
   int          lat;
   logic        pend;
   int          pcnt;
   logic [31:0] paddr;

   logic [31:0] q_pc   [$];
   logic [31:0] q_data [$];
   logic        q_c    [$];

   instruction_fetch_aligner dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .flush            (flush),
      .flushPc          (flushPc),
      .fetchReqValid    (fetchReqValid),
      .fetchReqReady    (fetchReqReady),
      .fetchReqAddr     (fetchReqAddr),
      .fetchRespValid   (fetchRespValid),
      .fetchRespData    (fetchRespData),
      .instValid        (instValid),
      .instReady        (instReady),
      .instData         (instData),
      .instPc           (instPc),
      .instIsCompressed (instIsCompressed)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // One clock: sample handshakes just before the edge, then advance the memory model.
   task automatic cyc();
      logic        hs;
      logic        rv;
      logic [31:0] a;
      #1;
      hs = fetchReqValid && fetchReqReady;
      a  = fetchReqAddr;
      rv = fetchRespValid;
      if (instValid && instReady && !flush) begin
         q_pc.push_back(instPc);
         q_data.push_back(instData);
         q_c.push_back(instIsCompressed);
      end
      @(posedge clk);
      #1;
      if (rv) begin
         fetchRespValid = 1'b0;
         pend = 1'b0;
      end
      if (hs) begin
         pend  = 1'b1;
         pcnt  = lat;
         paddr = a;
      end
      if (pend && !fetchRespValid) begin
         pcnt--;
         if (pcnt == 0) begin
            fetchRespValid = 1'b1;
            fetchRespData  = mem[paddr[9:2]];
         end
      end
   endtask

   task automatic settle_idle();
      instReady = 1'b0;
      lat       = 1;
      repeat (10) cyc();
   endtask

   task automatic do_flush(input logic [31:0] pc);
      q_pc.delete();
      q_data.delete();
      q_c.delete();
      flush   = 1'b1;
      flushPc = pc;
      #1;
      check("flush_masks_req", 32'(fetchReqValid), 32'd0);
      cyc();
      flush = 1'b0;
      #1;
   endtask

   task automatic collect(input string tag, input int n);
      int n_cyc = 0;
      while (q_pc.size() < n && n_cyc < 60) begin
         cyc();
         n_cyc++;
      end
      check({tag, "_count"}, 32'(q_pc.size() >= n ? n : q_pc.size()), 32'(n));
   endtask

   task automatic expect_inst(input string tag, input int k, input logic [31:0] pc,
                              input logic [31:0] data, input logic comp);
      if (k < q_pc.size()) begin
         check($sformatf("%s_pc%0d", tag, k), q_pc[k], pc);
         check($sformatf("%s_data%0d", tag, k), q_data[k], data);
         check($sformatf("%s_c%0d", tag, k), 32'(q_c[k]), 32'(comp));
      end
   endtask

   initial begin
      logic [31:0] t1 [4];
      t1 = '{32'h0010_0093, 32'h0020_0113, 32'h0030_0193, 32'h0040_0213};
      for (int i = 0; i < 256; i++) mem[i] = 32'h0;
      for (int i = 0; i < 4; i++) mem[i] = t1[i];
      rst_n = 1'b0; flush = 1'b0; flushPc = '0; fetchReqReady = 1'b1;
      fetchRespValid = 1'b0; fetchRespData = '0; instReady = 1'b0;
      lat = 1; pend = 1'b0; pcnt = 0; paddr = '0;

      #3;
      check("rst_reqValid", 32'(fetchReqValid), 32'd1);
      check("rst_reqAddr", fetchReqAddr, 32'h0);
      check("rst_instValid", 32'(instValid), 32'd0);
      check("rst_instData", instData, 32'h0);
      check("rst_instPc", instPc, 32'h0);
      check("rst_isComp", 32'(instIsCompressed), 32'd1);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Four 32-bit instructions straight out of reset
      instReady = 1'b1;
      collect("t1", 4);
      for (int k = 0; k < 4; k++) expect_inst("t1", k, 32'(4 * k), t1[k], 1'b0);

      // Two compressed instructions in one word
      settle_idle();
      mem[0] = 32'h4501_4081;
      mem[1] = 32'h0000_0000;
      instReady = 1'b1;
      do_flush(32'h0);
      collect("t2", 2);
      expect_inst("t2", 0, 32'h0, 32'h0000_4081, 1'b1);
      expect_inst("t2", 1, 32'h2, 32'h0000_4501, 1'b1);

      // 32-bit instruction straddling two words
      settle_idle();
      mem[0] = 32'h0013_4081;
      mem[1] = 32'h0000_0093;
      instReady = 1'b1;
      do_flush(32'h0);
      collect("t3", 2);
      expect_inst("t3", 0, 32'h0, 32'h0000_4081, 1'b1);
      expect_inst("t3", 1, 32'h2, 32'h0093_0013, 1'b0);

      // Idle flush into the upper halfword, with flush-to-instruction latency
      settle_idle();
      mem[8'h40] = 32'h4505_4111;
      mem[8'h41] = 32'h4089_4085;
      instReady = 1'b1;
      do_flush(32'h102);
      check("t4_reqValid", 32'(fetchReqValid), 32'd1);
      check("t4_reqAddr", fetchReqAddr, 32'h100);
      check("t4_noinst_c1", 32'(instValid), 32'd0);
      cyc();
      check("t4_noinst_c2", 32'(instValid), 32'd0);
      cyc();
      check("t4_inst_c3", 32'(instValid), 32'd1);
      collect("t4", 2);
      expect_inst("t4", 0, 32'h102, 32'h0000_4505, 1'b1);
      expect_inst("t4", 1, 32'h104, 32'h0000_4085, 1'b1);

      // Flush while BUSY; the stale response lands 3 cycles after its request
      settle_idle();
      mem[8'hC0] = 32'hDEAD_4BAD;
      mem[8'h80] = 32'h4121_4111;
      mem[8'h81] = 32'h4129_4125;
      instReady = 1'b1;
      lat = 3;
      do_flush(32'h300);
      check("t5_reqAddr_stale", fetchReqAddr, 32'h300);
      cyc();
      q_pc.delete(); q_data.delete(); q_c.delete();
      flush   = 1'b1;
      flushPc = 32'h200;
      #1;
      check("t5_busy_flush_mask", 32'(fetchReqValid), 32'd0);
      cyc();
      flush = 1'b0;
      #1;
      check("t5_drain_hold1", 32'(fetchReqValid), 32'd0);
      cyc();
      check("t5_drain_hold2", 32'(fetchReqValid), 32'd0);
      cyc();
      lat = 1;
      check("t5_req_after", 32'(fetchReqValid), 32'd1);
      check("t5_reqAddr", fetchReqAddr, 32'h200);
      check("t5_no_stale", 32'(instValid), 32'd0);
      collect("t5", 2);
      expect_inst("t5", 0, 32'h200, 32'h0000_4111, 1'b1);
      expect_inst("t5", 1, 32'h202, 32'h0000_4121, 1'b1);

      // Back-pressure: buffer fills to 4, fetch stops, then drains in order
      settle_idle();
      mem[0] = 32'h4085_4081;
      mem[1] = 32'h408D_4089;
      mem[2] = 32'h4095_4091;
      mem[3] = 32'h409D_4099;
      do_flush(32'h0);
      repeat (12) cyc();
      #1;
      check("t6_full_noreq", 32'(fetchReqValid), 32'd0);
      check("t6_full_valid", 32'(instValid), 32'd1);
      check("t6_full_head", instData, 32'h0000_4081);
      check("t6_full_pc", instPc, 32'h0);
      instReady = 1'b1;
      collect("t6", 6);
      for (int k = 0; k < 6; k++)
         expect_inst("t6", k, 32'(2 * k), 32'h0000_4081 + 32'(4 * k), 1'b1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
